// File: rtl/axi4_write_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : axi4_write_cmd_queue
// Description : Write command queue in front of axi4_master. Buffers
//               address/data requests in a FIFO, issues them one at a time
//               on the WRITE_START/READY/DONE/ERROR handshake and tracks
//               completions, error responses and lost (timed-out) writes.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4_write_cmd_queue #(
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DATA_WIDTH = 32,
    parameter int P_DEPTH      = 8,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic                      CLOCK,
    input  logic                      RESET,
    input  logic [P_ADDR_WIDTH-1:0]   S_ADDR,
    input  logic [P_DATA_WIDTH-1:0]   S_DATA,
    input  logic                      S_VALID,
    output logic                      S_READY,
    output logic [P_ADDR_WIDTH-1:0]   WRITE_ADDR,
    output logic [P_DATA_WIDTH-1:0]   WRITE_DATA,
    output logic                      WRITE_START,
    input  logic                      WRITE_READY,
    input  logic                      WRITE_DONE,
    input  logic                      WRITE_ERROR,
    output logic [$clog2(P_DEPTH):0]  FIFO_LEVEL,
    output logic                      BUSY,
    output logic [15:0]               DONE_COUNT,
    output logic [15:0]               ERR_COUNT,
    output logic                      TIMEOUT_ERR,
    input  logic                      CLEAR_ERR
);

    localparam int c_PTR_W = $clog2(P_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;
    localparam int c_TO_W  = $clog2(P_TIMEOUT);
    localparam int c_ENT_W = P_ADDR_WIDTH + P_DATA_WIDTH;

    localparam logic [0:0]         c_ST_IDLE  = 1'b0;
    localparam logic [0:0]         c_ST_WAIT  = 1'b1;
    localparam logic [c_LVL_W-1:0] c_LVL_FULL = c_LVL_W'(P_DEPTH);
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(P_TIMEOUT - 1);
    localparam logic [15:0]        c_CNT_MAX  = 16'hFFFF;

    // FIFO storage and pointers
    logic [c_ENT_W-1:0] r_mem [P_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    // Control and status registers
    logic [0:0]              r_state;
    logic [c_TO_W-1:0]       r_to_cnt;
    logic                    r_s_ready;
    logic                    r_start;
    logic [P_ADDR_WIDTH-1:0] r_addr;
    logic [P_DATA_WIDTH-1:0] r_data;
    logic                    r_busy;
    logic [15:0]             r_done_cnt;
    logic [15:0]             r_err_cnt;
    logic                    r_timeout_err;

    // Combinational helpers
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;
    logic               w_done_evt;
    logic               w_err_evt;
    logic               w_timeout_evt;
    logic [c_LVL_W-1:0] w_level_next;
    logic [0:0]         w_state_next;
    logic [15:0]        w_err_base;

    assign w_push        = S_VALID && r_s_ready;
    // Issue only from IDLE; the popped head is captured into WRITE_ADDR/DATA.
    assign w_pop         = (r_state == c_ST_IDLE) && (r_level != '0) && WRITE_READY;
    assign w_head        = r_mem[r_rd_ptr];
    assign w_done_evt    = (r_state == c_ST_WAIT) && WRITE_DONE;
    assign w_err_evt     = w_done_evt && WRITE_ERROR;
    // A DONE landing on the final timeout cycle takes precedence.
    assign w_timeout_evt = (r_state == c_ST_WAIT) && !WRITE_DONE && (r_to_cnt == c_TO_LAST);
    // A clear coinciding with a new error restarts the count at one.
    assign w_err_base    = CLEAR_ERR ? 16'd0 : r_err_cnt;

    // Next FIFO occupancy from simultaneous push/pop
    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_LVL_W'(1);
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - c_LVL_W'(1);
        end
    end

    // Next FSM state: IDLE issues, WAIT returns on DONE or timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_pop) w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (w_done_evt || w_timeout_evt) w_state_next = c_ST_IDLE;
            default:   w_state_next = c_ST_IDLE;
        endcase
    end

    // FIFO storage write; contents need no reset since pointers define validity
    always_ff @(posedge CLOCK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {S_ADDR, S_DATA};
        end
    end

    // Control path: pointers, FSM, registered outputs and statistics
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_state       <= c_ST_IDLE;
            r_to_cnt      <= '0;
            r_s_ready     <= 1'b0;
            r_start       <= 1'b0;
            r_addr        <= '0;
            r_data        <= '0;
            r_busy        <= 1'b0;
            r_done_cnt    <= '0;
            r_err_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_level   <= w_level_next;
            // Registered from the next occupancy so it always equals !full.
            r_s_ready <= (w_level_next != c_LVL_FULL);
            r_busy    <= (w_state_next != c_ST_IDLE) || (w_level_next != '0);
            r_start   <= w_pop;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                r_addr   <= w_head[c_ENT_W-1:P_DATA_WIDTH];
                r_data   <= w_head[P_DATA_WIDTH-1:0];
                r_to_cnt <= '0;
            end else if (r_state == c_ST_WAIT) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end

            if (w_done_evt) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end

            if (w_err_evt) begin
                r_err_cnt <= (w_err_base == c_CNT_MAX) ? w_err_base : w_err_base + 16'd1;
            end else if (CLEAR_ERR) begin
                r_err_cnt <= '0;
            end

            if (w_timeout_evt) begin
                r_timeout_err <= 1'b1;
            end else if (CLEAR_ERR) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign S_READY     = r_s_ready;
    assign WRITE_ADDR  = r_addr;
    assign WRITE_DATA  = r_data;
    assign WRITE_START = r_start;
    assign FIFO_LEVEL  = r_level;
    assign BUSY        = r_busy;
    assign DONE_COUNT  = r_done_cnt;
    assign ERR_COUNT   = r_err_cnt;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_axi4_write_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi4_write_cmd_queue
// Description : Self-checking bench for axi4_write_cmd_queue. A scoreboard
//               queue holds expected address/data in issue order; a simple
//               axi4_master responder returns DONE a fixed delay after start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi4_write_cmd_queue;

    localparam int c_DEPTH   = 8;
    localparam int c_TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] s_addr = '0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        write_start;
    logic        write_ready = 1'b0;
    logic        w_write_done;
    logic        write_error = 1'b0;
    logic [3:0]  fifo_level;
    logic        busy;
    logic [15:0] done_count;
    logic [15:0] err_count;
    logic        timeout_err;
    logic        clear_err = 1'b0;

    // Responder-driven and directly-driven DONE sources
    logic resp_done = 1'b0;
    logic tb_done   = 1'b0;
    assign w_write_done = resp_done | tb_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] sb_q[$];
    bit          resp_on    = 1'b1;
    int          resp_delay = 3;
    int          start_idx  = 0;
    int          err_target = -1;

    axi4_write_cmd_queue #(
        .P_ADDR_WIDTH (32),
        .P_DATA_WIDTH (32),
        .P_DEPTH      (c_DEPTH),
        .P_TIMEOUT    (c_TIMEOUT)
    ) u_dut (
        .CLOCK       (clock),
        .RESET       (reset),
        .S_ADDR      (s_addr),
        .S_DATA      (s_data),
        .S_VALID     (s_valid),
        .S_READY     (s_ready),
        .WRITE_ADDR  (write_addr),
        .WRITE_DATA  (write_data),
        .WRITE_START (write_start),
        .WRITE_READY (write_ready),
        .WRITE_DONE  (w_write_done),
        .WRITE_ERROR (write_error),
        .FIFO_LEVEL  (fifo_level),
        .BUSY        (busy),
        .DONE_COUNT  (done_count),
        .ERR_COUNT   (err_count),
        .TIMEOUT_ERR (timeout_err),
        .CLEAR_ERR   (clear_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one request for a cycle; expect_acc says whether the queue has room
    task automatic push(input logic [31:0] a, input logic [31:0] d, input bit expect_acc);
        s_addr  = a;
        s_data  = d;
        s_valid = 1'b1;
        chk("s_ready_at_push", {63'd0, s_ready}, {63'd0, expect_acc});
        if (expect_acc) sb_q.push_back({a, d});
        tick();
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while ((busy || fifo_level != 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("idle_reached", {63'd0, busy}, 64'd0);
    endtask

    task automatic wait_start(input int max_cyc);
        int n = 0;
        while (!write_start && n < max_cyc) begin
            tick();
            n++;
        end
        chk("start_seen", {63'd0, write_start}, 64'd1);
    endtask

    // Scoreboard: every issued start must carry the oldest accepted request
    always begin
        @(posedge clock);
        #2;
        if (reset && write_start) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_start", 64'd1, 64'd0);
            end else begin
                chk("issue_addr_data", {write_addr, write_data}, sb_q.pop_front());
            end
        end
    end

    // axi4_master model: DONE resp_delay cycles after each start
    always begin
        @(posedge clock);
        #3;
        if (reset && write_start) begin
            start_idx++;
            if (resp_on) begin
                automatic bit e = (start_idx == err_target);
                repeat (resp_delay) @(posedge clock);
                #1;
                resp_done   = 1'b1;
                write_error = e;
                @(posedge clock);
                #1;
                resp_done   = 1'b0;
                write_error = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_level", {60'd0, fifo_level}, 64'd0);
        chk("rst_start", {63'd0, write_start}, 64'd0);
        chk("rst_addr_data", {write_addr, write_data}, 64'd0);
        chk("rst_counts", {32'd0, done_count, err_count}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
        reset = 1'b1;
        tick();
        chk("s_ready_after_rst", {63'd0, s_ready}, 64'd1);

        // Two back-to-back requests, DONE 3 cycles after each start
        write_ready = 1'b1;
        push(32'h00, 32'hF1, 1'b1);
        push(32'h04, 32'hF2, 1'b1);
        s_valid = 1'b0;
        wait_idle(60);
        chk("t1_done_count", {48'd0, done_count}, 64'd2);
        chk("t1_sb_empty", sb_q.size(), 64'd0);

        // Fill while master busy; ninth request refused
        write_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push(32'h100 + 32'(i * 4), 32'hA0 + 32'(i), i < c_DEPTH);
        end
        s_valid = 1'b0;
        chk("t2_level_full", {60'd0, fifo_level}, 64'd8);
        chk("t2_s_ready_full", {63'd0, s_ready}, 64'd0);
        write_ready = 1'b1;
        wait_idle(200);
        chk("t2_level_empty", {60'd0, fifo_level}, 64'd0);
        chk("t2_done_count", {48'd0, done_count}, 64'd10);
        chk("t2_sb_empty", sb_q.size(), 64'd0);

        // Error response on the second of three writes
        err_target = start_idx + 2;
        for (int i = 0; i < 3; i++) push(32'h200 + 32'(i), 32'hB0 + 32'(i), 1'b1);
        s_valid = 1'b0;
        wait_idle(80);
        chk("t3_err_count", {48'd0, err_count}, 64'd1);
        chk("t3_done_count", {48'd0, done_count}, 64'd13);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t3_err_cleared", {48'd0, err_count}, 64'd0);

        // DONE on the last timeout cycle wins, then a genuine timeout
        resp_on = 1'b0;
        push(32'h300, 32'hC0, 1'b1);
        push(32'h304, 32'hC1, 1'b1);
        s_valid = 1'b0;
        wait_start(10);
        repeat (c_TIMEOUT - 1) tick();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        chk("t4_done_beats_timeout", {63'd0, timeout_err}, 64'd0);
        chk("t4_done_count", {48'd0, done_count}, 64'd14);
        tick();
        chk("t4_second_start", {63'd0, write_start}, 64'd1);
        repeat (c_TIMEOUT - 1) tick();
        chk("t4_no_timeout_early", {63'd0, timeout_err}, 64'd0);
        tick();
        chk("t4_timeout_set", {63'd0, timeout_err}, 64'd1);
        repeat (20) tick();
        chk("t4_timeout_sticky", {63'd0, timeout_err}, 64'd1);
        chk("t4_done_unchanged", {48'd0, done_count}, 64'd14);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t4_timeout_cleared", {63'd0, timeout_err}, 64'd0);
        chk("t4_sb_empty", sb_q.size(), 64'd0);

        // Reset while waiting with three entries queued
        for (int i = 0; i < 4; i++) push(32'h400 + 32'(i), 32'hD0 + 32'(i), 1'b1);
        s_valid = 1'b0;
        chk("t5_level_before", {60'd0, fifo_level}, 64'd3);
        chk("t5_busy_before", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        tick();
        sb_q.delete();
        chk("t5_level_rst", {60'd0, fifo_level}, 64'd0);
        chk("t5_busy_rst", {63'd0, busy}, 64'd0);
        chk("t5_counts_rst", {32'd0, done_count, err_count}, 64'd0);
        chk("t5_s_ready_rst", {63'd0, s_ready}, 64'd0);
        reset = 1'b1;
        tick();
        chk("t5_s_ready_back", {63'd0, s_ready}, 64'd1);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        tick();
        chk("t5_late_done_ignored", {48'd0, done_count}, 64'd0);
        chk("t5_busy_idle", {63'd0, busy}, 64'd0);

        // Simultaneous push and issue at level 4
        resp_on     = 1'b1;
        write_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h500 + 32'(i), 32'hE0 + 32'(i), 1'b1);
        s_valid = 1'b0;
        chk("t6_level4", {60'd0, fifo_level}, 64'd4);
        write_ready = 1'b1;
        push(32'h5FF, 32'hEF, 1'b1);
        s_valid = 1'b0;
        chk("t6_level_hold", {60'd0, fifo_level}, 64'd4);
        chk("t6_start", {63'd0, write_start}, 64'd1);
        wait_idle(100);
        chk("t6_done_count", {48'd0, done_count}, 64'd5);
        chk("t6_sb_empty", sb_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
